instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch sequencer for the simple 8-bit microprocessor; it is the producer side of the IR bus that the instruction decoder consumes. It reads opcode bytes from byte-wide program memory and, for address-carrying instructions, the two following address bytes. It presents the opcode on IR with the 16-bit operand on AR, and holds both until the execute stage accepts them. It also takes redirects for taken jumps.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset.
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_rd  output  1  read request; held high with mem_addr stable until mem_rvalid.
- mem_addr  output  16  byte address of the current read (equals pc while mem_rd=1).
- mem_rdata  input  8  read data, valid when mem_rvalid=1.
- mem_rvalid  input  1  one-cycle response strobe; earliest 1 cycle after mem_rd rises.
- ir  output  8  fetched opcode.
- ar  output  16  operand address, {high byte, low byte}.
- ir_valid  output  1  ir/ar hold a complete instruction.
- ir_ready  input  1  execute stage accepts ir/ar when ir_valid=1.
- redirect  input  1  one-cycle strobe: continue fetching from redirect_pc.
- redirect_pc  input  16  redirect target.
- pc  output  16  address of the next byte to fetch.
- illegal  output  1  opcode upper nibble non-zero (see Configuration).

## Operation
- Opcodes occupy 8'h00–8'h0F, low nibble selects the instruction.
- Three-byte instructions, encoded as opcode, addr low, addr high:
  - LDAC 8'h01, STAC 8'h02, JUMP 8'h05, JMPZ 8'h06, JPNZ 8'h07.
- All other opcodes are one byte.
- States:
  - OP: mem_rd=1. On mem_rvalid: ir<=mem_rdata, pc<=pc+1, ar<=0. Three-byte opcode -> LO, else -> ISSUE.
  - LO: mem_rd=1. On mem_rvalid: ar[7:0]<=mem_rdata, pc<=pc+1 -> HI.
  - HI: mem_rd=1. On mem_rvalid: ar[15:8]<=mem_rdata, pc<=pc+1 -> ISSUE.
  - ISSUE: ir_valid=1, ir/ar stable. On ir_ready -> OP.
  - DRAIN: mem_rd=1 with the aborted address. On mem_rvalid: data discarded, -> OP.
  - TRAP: only with the macro enabled (see Configuration).
- Redirect is accepted in every state except TRAP, and pc<=redirect_pc:
  - In OP/LO/HI with mem_rvalid=1 in the same cycle: the byte is discarded -> OP.
  - In OP/LO/HI with mem_rvalid=0: -> DRAIN. The request stays asserted at the old address until answered.
  - In DRAIN: pc is overwritten and the state stays DRAIN.
  - In ISSUE: ir_valid drops the next cycle, whether or not ir_ready was high (the instruction is consumed) -> OP.
- pc arithmetic is 16-bit modulo: 16'hFFFF+1 = 16'h0000. Operand bytes wrap the same way.
- mem_addr is pc in OP/LO/HI, and the latched aborted address in DRAIN.

## Timing
- Reset values: state OP, pc=RESET_PC, ir=8'h00, ar=16'h0000, ir_valid=0, illegal=0.
  - mem_rd is 0 during the reset cycle and 1 in the first cycle after it.
- Memory shares rst; no response is returned for a request issued before reset.
- With a 1-cycle memory:
  - One-byte instruction: ir_valid rises 2 cycles after entering OP.
  - Three-byte instruction: ir_valid rises 6 cycles after entering OP.
  - Back-to-back ir_ready=1 gives one issued instruction every 3 cycles (1-byte) or 7 cycles (3-byte).
- mem_rd deasserts for at least the cycle after mem_rvalid only when the next state is ISSUE. Otherwise the next request starts immediately.
- Reset mid-operation aborts everything; no instruction or partial operand survives.

## Configuration
- FETCH_ILLEGAL_TRAP_EN defined:
  - An opcode with a non-zero upper nibble loads ir, sets illegal=1 and enters TRAP.
  - In TRAP: mem_rd=0, ir_valid=0, redirect ignored, until rst.
- Undefined:
  - Such an opcode is issued as a one-byte instruction with ir as fetched; the decoder emits no strobe.
  - illegal pulses high for the ISSUE cycles of that instruction only.

## Test plan
- Reset, memory[0]=8'h0A (INAC), 1-cycle memory, ir_ready=1 -> mem_addr 0, ir_valid at cycle 2 with ir=8'h0A, ar=0; pc=1.
- memory[0..2]=8'h01,8'h34,8'h12 -> ir=8'h01, ar=16'h1234, pc=3, ir_valid at cycle 6.
- ir_ready=0 for 5 cycles in ISSUE -> ir/ar stable, mem_rd=0 throughout, and OP starts the cycle after ir_ready=1.
- redirect to 16'h0040 while in LO with a 3-cycle memory -> DRAIN holds the old mem_addr until mem_rvalid; the next read is at 16'h0040 and no instruction is issued from the aborted fetch.
- pc=16'hFFFF holding 8'h05 with operand bytes at 16'h0000 and 16'h0001 -> ar taken from those bytes, pc=16'h0002.
- opcode 8'h3C -> with FETCH_ILLEGAL_TRAP_EN: illegal=1, TRAP, no further mem_rd until rst. Without it: issued with ir=8'h3C, illegal=1 only during ISSUE.

Source files
------------

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch sequencer feeding ir/ar to the execute stage
// Define FETCH_ILLEGAL_TRAP_EN to halt in TRAP on an opcode with a non-zero upper nibble.
module instr_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_rvalid,
    output logic [7:0]  ir,
    output logic [15:0] ar,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] pc,
    output logic        illegal
);

    typedef enum logic [2:0] {
        S_OP    = 3'd0,
        S_LO    = 3'd1,
        S_HI    = 3'd2,
        S_ISSUE = 3'd3,
        S_DRAIN = 3'd4,
        S_TRAP  = 3'd5
    } state_t;

    state_t      state_q;
    logic [15:0] pc_q;
    logic [15:0] ar_q;
    logic [15:0] drain_addr_q;
    logic [7:0]  ir_q;
    logic        ir_valid_q;
    logic        illegal_q;

    logic [15:0] pc_inc_d;
    logic        op_long_d;
    logic        op_bad_d;
    logic        trap_d;
    logic        fetching_d;

    assign pc_inc_d   = pc_q + 16'd1;
    assign op_long_d  = mem_rdata inside {8'h01, 8'h02, 8'h05, 8'h06, 8'h07};
    assign op_bad_d   = (mem_rdata[7:4] != 4'h0);
    assign fetching_d = state_q inside {S_OP, S_LO, S_HI, S_DRAIN};

`ifdef FETCH_ILLEGAL_TRAP_EN
    assign trap_d = op_bad_d;
`else
    assign trap_d = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_OP;
            pc_q         <= RESET_PC;
            ar_q         <= 16'h0000;
            drain_addr_q <= 16'h0000;
            ir_q         <= 8'h00;
            ir_valid_q   <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            case (state_q)
                S_OP, S_LO, S_HI: begin
                    // A redirect without a response leaves a read outstanding; DRAIN absorbs it.
                    if (redirect) begin
                        pc_q         <= redirect_pc;
                        drain_addr_q <= pc_q;
                        state_q      <= mem_rvalid ? S_OP : S_DRAIN;
                    end else if (mem_rvalid) begin
                        pc_q <= pc_inc_d;
                        if (state_q == S_OP) begin
                            ir_q <= mem_rdata;
                            ar_q <= 16'h0000;
                            if (trap_d) begin
                                illegal_q <= 1'b1;
                                state_q   <= S_TRAP;
                            end else if (op_long_d) begin
                                state_q <= S_LO;
                            end else begin
                                state_q    <= S_ISSUE;
                                ir_valid_q <= 1'b1;
                                illegal_q  <= op_bad_d;
                            end
                        end else if (state_q == S_LO) begin
                            ar_q[7:0] <= mem_rdata;
                            state_q   <= S_HI;
                        end else begin
                            ar_q[15:8] <= mem_rdata;
                            state_q    <= S_ISSUE;
                            ir_valid_q <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    // A redirect consumes the presented instruction just like ir_ready.
                    if (redirect || ir_ready) begin
                        if (redirect) begin
                            pc_q <= redirect_pc;
                        end
                        ir_valid_q <= 1'b0;
                        illegal_q  <= 1'b0;
                        state_q    <= S_OP;
                    end
                end
                S_DRAIN: begin
                    if (redirect) begin
                        pc_q <= redirect_pc;
                    end
                    if (mem_rvalid) begin
                        state_q <= S_OP;
                    end
                end
                S_TRAP: begin
                    state_q <= S_TRAP;
                end
                default: begin
                    state_q <= S_OP;
                end
            endcase
        end
    end

    assign mem_rd   = fetching_d & ~rst;
    assign mem_addr = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
    assign ir       = ir_q;
    assign ar       = ar_q;
    assign ir_valid = ir_valid_q;
    assign pc       = pc_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed and randomized checks of instr_fetch against a program-walk model
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        mem_rvalid;
    logic [7:0]  ir;
    logic [15:0] ar;
    logic        ir_valid;
    logic        ir_ready;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] pc;
    logic        illegal;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(16'h0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .ir         (ir),
        .ar         (ar),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .pc         (pc),
        .illegal    (illegal)
    );

    logic [7:0] mem [0:65535];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit is_long(input logic [7:0] op);
        return (op == 8'h01) || (op == 8'h02) || (op == 8'h05) || (op == 8'h06) || (op == 8'h07);
    endfunction

    // Memory: accepts a request when idle, answers after a random latency, idles one cycle after.
    int          lat_min = 1;
    int          lat_max = 1;
    bit          busy;
    int          cnt;
    logic [15:0] raddr;
    logic        s_rd;
    logic        s_rst;
    logic [15:0] s_addr;

    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = 8'h00;
        busy       = 1'b0;
        cnt        = 0;
        raddr      = 16'h0;
        forever begin
            @(negedge clk);
            s_rd = mem_rd; s_addr = mem_addr; s_rst = rst;
            if (!s_rst && busy) begin
                check("rd_hold", 32'(s_rd), 32'd1);
                check("addr_hold", 32'(s_addr), 32'(raddr));
            end
            @(posedge clk); #1;
            if (s_rst || mem_rvalid) begin
                busy = 1'b0;
                mem_rvalid = 1'b0;
            end else begin
                if (!busy && s_rd) begin
                    busy = 1'b1; raddr = s_addr; cnt = $urandom_range(lat_max, lat_min);
                end
                if (busy) begin
                    cnt--;
                    if (cnt == 0) begin mem_rvalid = 1'b1; mem_rdata = mem[raddr]; end
                end
            end
        end
    end

    // Random-phase model: walk the program from model_pc, restart at each redirect target.
    bit          rand_on = 1'b0;
    bit          presented;
    int          issued;
    logic [15:0] model_pc;

    initial begin
        logic [7:0]  e_op;
        logic [15:0] e_ar, e_nxt, a1, a2;
        forever begin
            @(negedge clk);
            if (rand_on && !rst) begin
                if (ir_valid && !presented) begin
                    a1 = model_pc + 16'd1; a2 = model_pc + 16'd2;
                    e_op = mem[model_pc]; e_ar = 16'h0; e_nxt = a1;
                    if (is_long(e_op)) begin e_ar = {mem[a2], mem[a1]}; e_nxt = model_pc + 16'd3; end
                    check("rand_ir", 32'(ir), 32'(e_op));
                    check("rand_ar", 32'(ar), 32'(e_ar));
                    check("rand_pc", 32'(pc), 32'(e_nxt));
                    check("rand_illegal", 32'(illegal), 32'(e_op[7:4] != 4'h0));
                    model_pc = e_nxt; presented = 1'b1; issued++;
                end
                if (ir_valid && (ir_ready || redirect)) presented = 1'b0;
                if (redirect) model_pc = redirect_pc;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1; redirect = 1'b0; ir_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        @(negedge clk);
        while (!ir_valid && cyc < 60) begin cyc++; @(negedge clk); end
    endtask

    task automatic pulse_redirect(input logic [15:0] tgt);
        @(posedge clk); #1 redirect = 1'b1; redirect_pc = tgt;
        @(posedge clk); #1 redirect = 1'b0;
    endtask

    initial begin
        int c, k, n;
        int t [3];
        logic [7:0] ir_s [3];
        bit ok, saw;

        rst = 1'b1; redirect = 1'b0; redirect_pc = 16'h0; ir_ready = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

        // Reset state and a single-byte instruction
        mem[0] = 8'h0A;
        @(posedge clk); @(negedge clk);
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        check("rst_ir_valid", 32'(ir_valid), 32'd0);
        check("rst_pc", 32'(pc), 32'h0);
        check("rst_ir", 32'(ir), 32'h0);
        check("rst_ar", 32'(ar), 32'h0);
        check("rst_illegal", 32'(illegal), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("first_mem_rd", 32'(mem_rd), 32'd1);
        check("first_mem_addr", 32'(mem_addr), 32'h0);
        @(posedge clk); #1;
        wait_valid(c);
        check("inac_lat", 32'(c + 1), 32'd2);
        check("inac_ir", 32'(ir), 32'h0A);
        check("inac_ar", 32'(ar), 32'h0);
        check("inac_pc", 32'(pc), 32'h1);

        // Three-byte instruction, then a stall in ISSUE
        mem[0] = 8'h01; mem[1] = 8'h34; mem[2] = 8'h12;
        do_reset();
        wait_valid(c);
        check("ldac_lat", 32'(c), 32'd6);
        check("ldac_ir", 32'(ir), 32'h01);
        check("ldac_ar", 32'(ar), 32'h1234);
        check("ldac_pc", 32'(pc), 32'h3);
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (ir !== 8'h01 || ar !== 16'h1234 || mem_rd !== 1'b0 || ir_valid !== 1'b1) ok = 1'b0;
            @(negedge clk);
        end
        check("stall_stable", 32'(ok), 32'd1);
        @(posedge clk); #1 ir_ready = 1'b1;
        @(posedge clk); #1 ir_ready = 1'b0;
        @(negedge clk);
        check("accept_mem_rd", 32'(mem_rd), 32'd1);
        check("accept_valid", 32'(ir_valid), 32'd0);
        check("accept_addr", 32'(mem_addr), 32'h3);

        // Back-to-back issue rate
        mem[0] = 8'h0A; mem[1] = 8'h0A; mem[2] = 8'h01; mem[3] = 8'h34; mem[4] = 8'h12; mem[5] = 8'h0A;
        do_reset();
        ir_ready = 1'b1;
        c = 0; k = 0;
        while (k < 3 && c < 60) begin
            @(negedge clk);
            if (ir_valid) begin t[k] = c; ir_s[k] = ir; k++; end
            c++;
        end
        ir_ready = 1'b0;
        check("b2b_count", 32'(k), 32'd3);
        check("b2b_first", 32'(t[0]), 32'd2);
        check("b2b_gap1", 32'(t[1] - t[0]), 32'd3);
        check("b2b_gap3", 32'(t[2] - t[1]), 32'd7);
        check("b2b_ir3", 32'(ir_s[2]), 32'h01);

        // Redirect while LO waits on a slow memory
        mem[0] = 8'h01; mem[1] = 8'h34; mem[2] = 8'h12; mem[16'h40] = 8'h0A;
        lat_min = 3; lat_max = 3;
        do_reset();
        n = 0;
        @(negedge clk);
        while (!(mem_rd && mem_addr == 16'h1) && n < 30) begin n++; @(negedge clk); end
        check("lo_reached", 32'(n < 30), 32'd1);
        pulse_redirect(16'h0040);
        @(negedge clk);
        check("drain_addr", 32'(mem_addr), 32'h1);
        check("drain_pc", 32'(pc), 32'h40);
        saw = ir_valid; n = 0;
        while (!mem_rvalid && n < 20) begin n++; @(negedge clk); saw |= ir_valid; end
        check("drain_resp_addr", 32'(mem_addr), 32'h1);
        @(negedge clk);
        check("post_drain_addr", 32'(mem_addr), 32'h40);
        check("post_drain_rd", 32'(mem_rd), 32'd1);
        check("no_aborted_issue", 32'(saw), 32'd0);
        wait_valid(c);
        check("redir_ir", 32'(ir), 32'h0A);
        check("redir_pc", 32'(pc), 32'h41);

        // Redirect from ISSUE into an instruction straddling the address wrap
        lat_min = 1; lat_max = 1;
        mem[16'hFFFF] = 8'h05; mem[0] = 8'hCD; mem[1] = 8'hAB; mem[2] = 8'h3C; mem[3] = 8'h0A;
        pulse_redirect(16'hFFFF);
        wait_valid(c);
        check("wrap_lat", 32'(c), 32'd6);
        check("wrap_ir", 32'(ir), 32'h05);
        check("wrap_ar", 32'(ar), 32'hABCD);
        check("wrap_pc", 32'(pc), 32'h2);

        // Illegal opcode 8'h3C
        @(posedge clk); #1 ir_ready = 1'b1;
        @(posedge clk); #1 ir_ready = 1'b0;
`ifdef FETCH_ILLEGAL_TRAP_EN
        repeat (4) @(negedge clk);
        check("trap_illegal", 32'(illegal), 32'd1);
        check("trap_ir", 32'(ir), 32'h3C);
        ok = 1'b1;
        fork
            pulse_redirect(16'h0000);
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (mem_rd !== 1'b0 || ir_valid !== 1'b0) ok = 1'b0;
            end
        join
        check("trap_quiet", 32'(ok), 32'd1);
`else
        wait_valid(c);
        check("ill_ir", 32'(ir), 32'h3C);
        check("ill_flag", 32'(illegal), 32'd1);
        check("ill_pc", 32'(pc), 32'h3);
        @(posedge clk); #1 ir_ready = 1'b1;
        @(posedge clk); #1 ir_ready = 1'b0;
        @(negedge clk);
        check("ill_drop", 32'(illegal), 32'd0);
        wait_valid(c);
        check("after_ill_ir", 32'(ir), 32'h0A);
        check("after_ill_flag", 32'(illegal), 32'd0);
`endif

        // Randomized program, latency, back-pressure and redirects
        for (int i = 0; i < 65536; i++) begin
`ifdef FETCH_ILLEGAL_TRAP_EN
            mem[i] = 8'($urandom_range(15, 0));
`else
            mem[i] = ($urandom_range(9, 0) != 0) ? 8'($urandom_range(15, 0)) : 8'($urandom);
`endif
        end
        lat_min = 1; lat_max = 4;
        model_pc = 16'h0000; presented = 1'b0; issued = 0; rand_on = 1'b1;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            ir_ready = ($urandom_range(3, 0) != 0);
            redirect = ($urandom_range(39, 0) == 0);
            if (redirect)
                redirect_pc = ($urandom_range(1, 0) == 1) ? 16'($urandom_range(255, 0))
                                                           : 16'hFFF0 + 16'($urandom_range(15, 0));
        end
        @(posedge clk); #1 redirect = 1'b0; ir_ready = 1'b0;
        @(negedge clk);
        rand_on = 1'b0;
        check("rand_progress", 32'(issued > 50), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
